// File: rtl/i2s_pkg.sv
// Shared state type and word-select helper for the I2S transmitter slice.
package i2s_pkg;

    localparam int DEFAULT_DATA_SIZE = 16;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_state_t;

    // Standard I2S framing: WS leads each channel's MSB by one bit period.
    function automatic logic ws_for_bit(input int bit_idx, input int data_size);
        return (bit_idx >= data_size - 1) && (bit_idx <= 2 * data_size - 2);
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags the clk cycle before each SCK edge.
module i2s_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sck,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick     = enable && (div_cnt == DIV_LAST);
    assign fall_evt = tick && sck;
    assign rise_evt = tick && !sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter with a one-entry sample holding register.
// Define I2S_TX_UNDERRUN_REPEAT_EN to repeat the last pair on underrun instead of sending silence.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] sample_l,
    input  logic [DATA_SIZE-1:0] sample_r,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 i2s_sck,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun
);

    localparam int FRAME_BITS = 2 * DATA_SIZE;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef struct packed {
        logic [DATA_SIZE-1:0] left;
        logic [DATA_SIZE-1:0] right;
    } pair_t;

    i2s_state_t            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_nxt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] fill_pair;
    pair_t                 hold_pair;
    logic                  hold_full;
    logic                  accept;
    logic                  fall_evt;
    logic                  rise_evt_unused;
    logic                  frame_load;

    i2s_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .enable   (state == RUN),
        .sck      (i2s_sck),
        .fall_evt (fall_evt),
        .rise_evt (rise_evt_unused)
    );

    assign sample_ready = ~hold_full;
    assign accept       = sample_valid && !hold_full;
    assign bit_cnt_nxt  = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    assign frame_load   = fall_evt && (bit_cnt == LAST_BIT);
    assign i2s_sd       = shift_reg[FRAME_BITS-1];

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    pair_t last_pair;

    // Every load overwrites this before any underrun can occur, so it needs no reset.
    always_ff @(posedge clk) begin
        if (frame_load && hold_full) begin
            last_pair <= hold_pair;
        end
    end

    assign fill_pair = last_pair;
`else
    assign fill_pair = '0;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_pair <= '{left: sample_l, right: sample_r};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            i2s_ws    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            // A pair arriving on the load clk of an empty register waits for the next frame.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (frame_load) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        bit_cnt <= LAST_BIT;
                    end
                end
                RUN: begin
                    if (fall_evt) begin
                        bit_cnt <= bit_cnt_nxt;
                        i2s_ws  <= ws_for_bit(int'(bit_cnt_nxt), DATA_SIZE);
                        if (frame_load) begin
                            if (hold_full) begin
                                shift_reg <= hold_pair;
                            end else begin
                                shift_reg <= fill_pair;
                                underrun  <= 1'b1;
                            end
                        end else begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: an I2S receiver model decodes the serial stream
// and compares it with a frame-level model of accepted pairs and underrun fills.
`timescale 1ns/1ps
module tb_i2s_transmitter;

    localparam int DS        = 16;
    localparam int CD        = 2;
    localparam int FRAME_CLK = 2 * DS * 2 * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DS-1:0] sample_l = '0;
    logic [DS-1:0] sample_r = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          i2s_sck;
    logic          i2s_ws;
    logic          i2s_sd;
    logic          underrun;

    i2s_transmitter #(
        .DATA_SIZE (DS),
        .CLK_DIV   (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Receiver model: samples on SCK rise; a WS change marks the LSB of the channel just ending.
    logic [DS:0]   got_q[$];
    logic [DS-1:0] rx_word;
    logic          rx_prev_ws;
    always @(posedge i2s_sck or posedge rst) begin
        if (rst) begin
            rx_word    <= '0;
            rx_prev_ws <= 1'b0;
            got_q.delete();
        end else begin
            rx_word    <= {rx_word[DS-2:0], i2s_sd};
            rx_prev_ws <= i2s_ws;
            if (i2s_ws !== rx_prev_ws)
                got_q.push_back({rx_prev_ws, rx_word[DS-2:0], i2s_sd});
        end
    end

    int sck_edges = 0;
    always @(posedge i2s_sck or negedge i2s_sck) sck_edges <= sck_edges + 1;

    int   ur_pulses;
    int   ur_width;
    int   ur_maxw;
    logic ur_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ur_pulses <= 0;
            ur_width  <= 0;
            ur_maxw   <= 0;
            ur_prev   <= 1'b0;
        end else begin
            ur_prev <= underrun;
            if (underrun && !ur_prev) ur_pulses <= ur_pulses + 1;
            if (underrun) ur_width <= ur_width + 1;
            else          ur_width <= 0;
            if (underrun && (ur_width + 1 > ur_maxw)) ur_maxw <= ur_width + 1;
        end
    end

    // Frame-level reference: each frame carries either an accepted pair or the underrun fill.
    logic [DS:0]   exp_q[$];
    logic [DS-1:0] model_last_l;
    logic [DS-1:0] model_last_r;

    task automatic exp_frame(input logic [DS-1:0] l, input logic [DS-1:0] r);
        exp_q.push_back({1'b0, l});
        exp_q.push_back({1'b1, r});
        model_last_l = l;
        model_last_r = r;
    endtask

    task automatic exp_underrun();
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        exp_q.push_back({1'b0, model_last_l});
        exp_q.push_back({1'b1, model_last_r});
`else
        exp_q.push_back({1'b0, {DS{1'b0}}});
        exp_q.push_back({1'b1, {DS{1'b0}}});
`endif
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_last_l = '0;
        model_last_r = '0;
    endtask

    // Holds valid until accepted; returns at the negedge after the accepting edge.
    task automatic push(input string tag, input logic [DS-1:0] l, input logic [DS-1:0] r);
        bit ok;
        ok = 1'b0;
        sample_l = l;
        sample_r = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (sample_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        check({tag, "_accept"}, 64'(ok), 64'(1));
    endtask

    task automatic wait_words(input string tag, input int n);
        for (int i = 0; i < FRAME_CLK * 8 && got_q.size() < n; i++) @(negedge clk);
        check({tag, "_timeout"}, 64'(got_q.size() >= n), 64'(1));
    endtask

    task automatic compare_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            else
                check($sformatf("%s_w%0d_missing", tag, i), 64'(got_q.size()), 64'(i + 1));
        end
    endtask

    initial begin
        logic [DS-1:0] pl[3];
        logic [DS-1:0] pr[3];
        int edges0;
        int lat;

        // Reset and idle
        #1;
        check("rst_sck", 64'(i2s_sck), 64'(0));
        check("rst_ws", 64'(i2s_ws), 64'(0));
        check("rst_sd", 64'(i2s_sd), 64'(0));
        check("rst_ready", 64'(sample_ready), 64'(1));
        check("rst_underrun", 64'(underrun), 64'(0));
        do_reset();
        edges0 = sck_edges;
        repeat (50) @(negedge clk);
        check("idle_sck_edges", 64'(sck_edges - edges0), 64'(0));
        check("idle_ws", 64'(i2s_ws), 64'(0));
        check("idle_sd", 64'(i2s_sd), 64'(0));
        check("idle_ready", 64'(sample_ready), 64'(1));

        // Single fixed pair, then the frame that follows underruns
        do_reset();
        push("single", 16'hA5C3, 16'h0F01);
        check("single_ready_low", 64'(sample_ready), 64'(0));
        lat = 0;
        for (int i = 0; i < 20 && sample_ready !== 1'b1; i++) begin
            @(negedge clk);
            lat++;
        end
        check("single_ready_latency", 64'(lat), 64'(2 * CD));
        exp_frame(16'hA5C3, 16'h0F01);
        exp_underrun();
        wait_words("single", 4);
        compare_stream("single");

        // Back-to-back random pairs
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pl[k] = DS'($urandom);
            pr[k] = DS'($urandom);
            push($sformatf("b2b%0d", k), pl[k], pr[k]);
            exp_frame(pl[k], pr[k]);
        end
        wait_words("b2b", 6);
        check("b2b_no_underrun", 64'(ur_pulses), 64'(0));
        exp_underrun();
        wait_words("b2b_tail", 8);
        check("b2b_tail_underrun", 64'(ur_pulses), 64'(1));
        compare_stream("b2b");

        // Stall after one pair
        do_reset();
        pl[0] = DS'($urandom);
        pr[0] = DS'($urandom);
        push("stall", pl[0], pr[0]);
        exp_frame(pl[0], pr[0]);
        exp_underrun();
        wait_words("stall", 4);
        check("stall_underrun_count", 64'(ur_pulses), 64'(1));
        check("stall_underrun_width", 64'(ur_maxw), 64'(1));
        compare_stream("stall");

        // Valid arrives exactly on the second frame-load clk with an empty register
        do_reset();
        pl[0] = DS'($urandom);
        pr[0] = DS'($urandom);
        pl[1] = DS'($urandom);
        pr[1] = DS'($urandom);
        push("coinc0", pl[0], pr[0]);
        repeat (FRAME_CLK + 2 * CD - 1) @(negedge clk);
        check("coinc_ready_before", 64'(sample_ready), 64'(1));
        sample_l = pl[1];
        sample_r = pr[1];
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        check("coinc_captured", 64'(sample_ready), 64'(0));
        exp_frame(pl[0], pr[0]);
        exp_underrun();
        exp_frame(pl[1], pr[1]);
        wait_words("coinc", 6);
        check("coinc_underrun_count", 64'(ur_pulses), 64'(1));
        compare_stream("coinc");

        // Asynchronous reset in the middle of a frame (bit 20, right slot)
        do_reset();
        push("midrst", DS'($urandom), DS'($urandom));
        repeat (2 * CD + 20 * 2 * CD + 2) @(negedge clk);
        check("midrst_ws_before", 64'(i2s_ws), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("midrst_sck", 64'(i2s_sck), 64'(0));
        check("midrst_ws", 64'(i2s_ws), 64'(0));
        check("midrst_sd", 64'(i2s_sd), 64'(0));
        check("midrst_ready", 64'(sample_ready), 64'(1));
        check("midrst_underrun", 64'(underrun), 64'(0));
        @(negedge clk);
        do_reset();
        pl[2] = DS'($urandom);
        pr[2] = DS'($urandom);
        push("after_rst", pl[2], pr[2]);
        exp_frame(pl[2], pr[2]);
        wait_words("after_rst", 2);
        compare_stream("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
